// File: rtl/kmeans_pkg.sv
// kmeans_pkg: register map, control/status bit positions and APB FSM states
package kmeans_pkg;
  localparam logic [7:0] CTRL_ADDR    = 8'h00;
  localparam logic [7:0] STATUS_ADDR  = 8'h01;
  localparam logic [7:0] NPOINTS_ADDR = 8'h02;
  localparam logic [7:0] CEN_BASE     = 8'h08;
  localparam logic [7:0] PT_BASE      = 8'h80;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} apb_state_e;
endpackage

// File: rtl/kmeans_apb_regfile_if.sv
// kmeans_apb_regfile_if: APB3 bus between host and the k-means register file
interface kmeans_apb_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 91
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (output paddr, pwrite, psel, penable, pwdata, input prdata, pready, pslverr);
  modport slave  (input paddr, pwrite, psel, penable, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/kmeans_point_mem.sv
// kmeans_point_mem: point storage, one APB write port and two combinational read ports
module kmeans_point_mem #(
  parameter int NUM_POINTS = 128,
  parameter int DATA_WIDTH = 91,
  localparam int AW = $clog2(NUM_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]         raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);
  logic [DATA_WIDTH-1:0] mem [NUM_POINTS];
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/kmeans_apb_regfile.sv
// kmeans_apb_regfile: APB3 completer holding k-means control, status, centroids and points
module kmeans_apb_regfile
  import kmeans_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 91,
  parameter int NUM_CENTROIDS = 8,
  parameter int NUM_POINTS    = 128,
  localparam int PW = $clog2(NUM_POINTS),
  localparam int CW = $clog2(NUM_CENTROIDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  kmeans_apb_regfile_if.slave   apb,
  output logic                  core_start,
  output logic [7:0]            core_npoints,
  input  logic                  core_busy,
  input  logic                  core_done,
  input  logic [PW-1:0]         pt_raddr,
  output logic [DATA_WIDTH-1:0] pt_rdata,
  input  logic                  cen_we,
  input  logic [CW-1:0]         cen_waddr,
  input  logic [DATA_WIDTH-1:0] cen_wdata
);
  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            npoints;
  logic                  done;
  logic [DATA_WIDTH-1:0] cen [NUM_CENTROIDS];
  logic [DATA_WIDTH-1:0] pt_apb_rdata, rd_mux, status;
  logic setup, acc, is_ctrl, is_status, is_np, is_cen, is_pt, np_bad, err, commit, capture;
  assign setup     = apb.psel && !apb.penable;
  assign acc       = apb.psel && apb.penable;
  assign is_ctrl   = addr_q == ADDR_WIDTH'(CTRL_ADDR);
  assign is_status = addr_q == ADDR_WIDTH'(STATUS_ADDR);
  assign is_np     = addr_q == ADDR_WIDTH'(NPOINTS_ADDR);
  assign is_cen    = addr_q >= ADDR_WIDTH'(CEN_BASE) && addr_q < ADDR_WIDTH'(int'(CEN_BASE) + NUM_CENTROIDS);
  assign is_pt     = addr_q >= ADDR_WIDTH'(PT_BASE);
  assign np_bad    = wdata_q == '0 || wdata_q > DATA_WIDTH'(NUM_POINTS);
  // Write legality uses core_busy at the completing edge, not at setup
  assign err = !(is_ctrl || is_status || is_np || is_cen || is_pt) ||
               (wr_q && (is_status || (is_np && np_bad) ||
                (core_busy && (is_cen || is_pt || is_np || (is_ctrl && wdata_q[CTRL_START])))));
  assign commit      = state_q == ACCESS && wr_q && acc && !err;
  assign capture     = state_q == ACCESS && acc && (!wr_q || err);
  assign apb.pready  = acc && ((state_q == ACCESS && wr_q) || state_q == WAIT);
  assign apb.pslverr = apb.pready && err;
  assign core_npoints = npoints;
  always_comb begin
    state_d = state_q == IDLE ? (setup ? ACCESS : IDLE) :
              state_q == ACCESS && acc && !wr_q ? WAIT : IDLE;
  end
  always_comb begin
    status = '0;
    status[STAT_BUSY] = core_busy;
    status[STAT_DONE] = done;
    rd_mux = is_status ? status :
             is_np     ? DATA_WIDTH'(npoints) :
             is_cen    ? cen[addr_q[CW-1:0]] :
             is_pt     ? pt_apb_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      apb.prdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup) begin
        addr_q  <= apb.paddr;
        wr_q    <= apb.pwrite;
        wdata_q <= apb.pwdata;
      end
      if (capture) apb.prdata <= err ? '0 : rd_mux;
    end
  // Start and clear both drop a stale done; a simultaneous core_done still sets it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      npoints    <= '0;
      done       <= 1'b0;
      core_start <= 1'b0;
    end else begin
      if (commit && is_np) npoints <= wdata_q[7:0];
      core_start <= commit && is_ctrl && wdata_q[CTRL_START];
      done <= core_done || (done && !(commit && is_ctrl && (wdata_q[CTRL_START] || wdata_q[CTRL_CLEAR])));
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) cen <= '{default: '0};
    else if (commit && is_cen) cen[addr_q[CW-1:0]] <= wdata_q;
    else if (cen_we && core_busy) cen[cen_waddr] <= cen_wdata;
  kmeans_point_mem #(.NUM_POINTS(NUM_POINTS), .DATA_WIDTH(DATA_WIDTH)) u_pt (
    .clk     (clk),
    .rst     (rst),
    .we      (commit && is_pt),
    .waddr   (addr_q[PW-1:0]),
    .wdata   (wdata_q),
    .raddr_a (addr_q[PW-1:0]),
    .rdata_a (pt_apb_rdata),
    .raddr_b (pt_raddr),
    .rdata_b (pt_rdata)
  );
endmodule
